// File: rtl/lcd_ctrl_param.sv
// Parametrised image display controller: loads an IMG_W x IMG_H image from IROM,
// applies 2x2-kernel commands at a movable operation point and streams the image to IRAM.
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done,
    output logic          cmd_err
);
    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [AW-1:0] A_ZERO = '0;
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);
    localparam logic [XW-1:0] X_INIT = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_INIT = YW'(IMG_H / 2);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);

    localparam logic [1:0] S_LOAD      = 2'd0;
    localparam logic [1:0] S_LOAD_LAST = 2'd1;
    localparam logic [1:0] S_IDLE      = 2'd2;
    localparam logic [1:0] S_WRITE     = 2'd3;

    localparam logic [3:0] C_WRITE  = 4'd0;
    localparam logic [3:0] C_UP     = 4'd1;
    localparam logic [3:0] C_DOWN   = 4'd2;
    localparam logic [3:0] C_LEFT   = 4'd3;
    localparam logic [3:0] C_RIGHT  = 4'd4;
    localparam logic [3:0] C_MAX    = 4'd5;
    localparam logic [3:0] C_MIN    = 4'd6;
    localparam logic [3:0] C_AVG    = 4'd7;
    localparam logic [3:0] C_CCW    = 4'd8;
    localparam logic [3:0] C_CW     = 4'd9;
    localparam logic [3:0] C_MIRX   = 4'd10;
    localparam logic [3:0] C_MIRY   = 4'd11;
    localparam logic [3:0] C_RELOAD = 4'd12;

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Two guard bits hold the full four-pixel sum, so the floored mean never wraps.
    function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [DW+1:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[DW+1:2];
    endfunction

    logic [1:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] img [N];

    logic          ld_vld_p1;
    logic [AW-1:0] ld_addr_p1;

    logic [XW-1:0] xm1;
    logic [YW-1:0] ym1;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [DW-1:0] p0, p1, p2, p3;
    logic [DW-1:0] n0, n1, n2, n3;
    logic [DW-1:0] k_val;
    logic          k_we;
    logic          accept;
    logic [AW-1:0] wr_next;

    assign accept  = (state == S_IDLE) && cmd_valid;
    assign xm1     = x - X_ONE;
    assign ym1     = y - Y_ONE;
    assign a0      = {ym1, xm1};
    assign a1      = {ym1, x};
    assign a2      = {y, xm1};
    assign a3      = {y, x};
    assign p0      = img[a0];
    assign p1      = img[a1];
    assign p2      = img[a2];
    assign p3      = img[a3];
    assign wr_next = IRAM_A + A_ONE;

    always_comb begin
        k_we  = 1'b0;
        k_val = '0;
        n0    = p0;
        n1    = p1;
        n2    = p2;
        n3    = p3;
        if (accept) begin
            case (cmd)
                C_MAX:  begin k_we = 1'b1; k_val = max2(max2(p0, p1), max2(p2, p3)); end
                C_MIN:  begin k_we = 1'b1; k_val = min2(min2(p0, p1), min2(p2, p3)); end
                C_AVG:  begin k_we = 1'b1; k_val = avg4(p0, p1, p2, p3); end
                C_CCW:  begin k_we = 1'b1; n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
                C_CW:   begin k_we = 1'b1; n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
                C_MIRX: begin k_we = 1'b1; n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
                C_MIRY: begin k_we = 1'b1; n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
                default: ;
            endcase
            if (cmd == C_MAX || cmd == C_MIN || cmd == C_AVG) begin
                n0 = k_val;
                n1 = k_val;
                n2 = k_val;
                n3 = k_val;
            end
        end
    end

    // Image buffer: ROM capture stage (one cycle behind the address) or kernel update.
    always_ff @(posedge clk) begin
        if (ld_vld_p1) begin
            img[ld_addr_p1] <= IROM_Q;
        end else if (k_we) begin
            img[a0] <= n0;
            img[a1] <= n1;
            img[a2] <= n2;
            img[a3] <= n3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_LOAD;
            x          <= X_INIT;
            y          <= Y_INIT;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
            ld_vld_p1  <= 1'b0;
            ld_addr_p1 <= '0;
        end else begin
            done       <= 1'b0;
            cmd_err    <= 1'b0;
            ld_vld_p1  <= IROM_rd;
            ld_addr_p1 <= IROM_A;
            case (state)
                S_LOAD: begin
                    // Coming out of reset the read enable is raised first, with address 0 already set.
                    if (!IROM_rd) begin
                        IROM_rd <= 1'b1;
                    end else if (IROM_A == A_LAST) begin
                        IROM_rd <= 1'b0;
                        state   <= S_LOAD_LAST;
                    end else begin
                        IROM_A <= IROM_A + A_ONE;
                    end
                end
                S_LOAD_LAST: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            C_WRITE: begin
                                busy       <= 1'b1;
                                state      <= S_WRITE;
                                IRAM_valid <= 1'b1;
                                IRAM_A     <= A_ZERO;
                                IRAM_D     <= img[A_ZERO];
                            end
                            C_RELOAD: begin
                                busy    <= 1'b1;
                                state   <= S_LOAD;
                                IROM_rd <= 1'b1;
                                IROM_A  <= A_ZERO;
                            end
                            C_UP:    if (y > Y_ONE) y <= y - Y_ONE;
                            C_DOWN:  if (y < Y_MAX) y <= y + Y_ONE;
                            C_LEFT:  if (x > X_ONE) x <= x - X_ONE;
                            C_RIGHT: if (x < X_MAX) x <= x + X_ONE;
                            4'd13, 4'd14, 4'd15: cmd_err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (IRAM_A == A_LAST) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        IRAM_A <= wr_next;
                        IRAM_D <= img[wr_next];
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Scoreboard bench for lcd_ctrl_param: an 8x8 instance driven by a reference image model,
// plus a 16x4 instance exercising operation-point clamping on a non-square image.
module tb_lcd_ctrl_param;
    typedef struct {
        int a;
        int d;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] cmd, cmd2;
    logic       cmd_valid, cmd_valid2;
    logic [7:0] irom_q, irom_q2, iram_d, iram_d2;
    logic [5:0] irom_a, irom_a2, iram_a, iram_a2;
    logic       irom_rd, irom_rd2, iram_valid, iram_valid2;
    logic       busy, busy2, done, done2, cmd_err, cmd_err2;

    int   rom [64];
    int   mimg [64];
    int   ram [64];
    int   ram2 [64];
    int   wr2_cnt;
    int   rx, ry;
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lcd_ctrl_param #(.DW(8), .IMG_W(8), .IMG_H(8)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(irom_q),
        .IROM_rd(irom_rd), .IROM_A(irom_a), .IRAM_valid(iram_valid), .IRAM_D(iram_d),
        .IRAM_A(iram_a), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    lcd_ctrl_param #(.DW(8), .IMG_W(16), .IMG_H(4)) dut2 (
        .clk(clk), .reset(reset), .cmd(cmd2), .cmd_valid(cmd_valid2), .IROM_Q(irom_q2),
        .IROM_rd(irom_rd2), .IROM_A(irom_a2), .IRAM_valid(iram_valid2), .IRAM_D(iram_d2),
        .IRAM_A(iram_a2), .busy(busy2), .done(done2), .cmd_err(cmd_err2)
    );

    always #5 clk = ~clk;

    // ROM macros: data for the address seen at the previous edge.
    always @(posedge clk) begin
        irom_q  <= 8'(rom[irom_a]);
        irom_q2 <= {2'b00, irom_a2};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (iram_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", iram_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("iram_a", iram_a, e.a);
                chk("iram_d", iram_d, e.d);
            end
            ram[iram_a] = iram_d;
        end
        if (iram_valid2) begin
            ram2[iram_a2] = iram_d2;
            wr2_cnt++;
        end
    end

    // Reference model of the 8x8 instance, updated when a command is accepted.
    task automatic model_cmd(input logic [3:0] c);
        int i0, i1, i2, i3, v0, v1, v2, v3, m;
        i0 = (ry - 1) * 8 + rx - 1;
        i1 = i0 + 1;
        i2 = ry * 8 + rx - 1;
        i3 = i2 + 1;
        v0 = mimg[i0]; v1 = mimg[i1]; v2 = mimg[i2]; v3 = mimg[i3];
        case (c)
            4'd0: for (int i = 0; i < 64; i++) sb.push_back('{a: i, d: mimg[i]});
            4'd1: if (ry > 1) ry--;
            4'd2: if (ry < 7) ry++;
            4'd3: if (rx > 1) rx--;
            4'd4: if (rx < 7) rx++;
            4'd5: begin
                m = v0;
                if (v1 > m) m = v1;
                if (v2 > m) m = v2;
                if (v3 > m) m = v3;
                mimg[i0] = m; mimg[i1] = m; mimg[i2] = m; mimg[i3] = m;
            end
            4'd6: begin
                m = v0;
                if (v1 < m) m = v1;
                if (v2 < m) m = v2;
                if (v3 < m) m = v3;
                mimg[i0] = m; mimg[i1] = m; mimg[i2] = m; mimg[i3] = m;
            end
            4'd7: begin
                m = (v0 + v1 + v2 + v3) / 4;
                mimg[i0] = m; mimg[i1] = m; mimg[i2] = m; mimg[i3] = m;
            end
            4'd8:  begin mimg[i0] = v1; mimg[i1] = v3; mimg[i2] = v0; mimg[i3] = v2; end
            4'd9:  begin mimg[i0] = v2; mimg[i1] = v0; mimg[i2] = v3; mimg[i3] = v1; end
            4'd10: begin mimg[i0] = v2; mimg[i1] = v3; mimg[i2] = v0; mimg[i3] = v1; end
            4'd11: begin mimg[i0] = v1; mimg[i1] = v0; mimg[i2] = v3; mimg[i3] = v2; end
            4'd12: mimg = rom;
            default: ;
        endcase
    endtask

    task automatic send(input logic [3:0] c);
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        model_cmd(c);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Follows a load from its first read cycle to busy falling; reserved codes are held
    // on cmd throughout and must be ignored while busy.
    task automatic measure_load(input string tag);
        int edges = 0, first = -1, rd_cnt = 0;
        bit seq_ok = 1'b1, err_seen = 1'b0;
        while (edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            cmd = 4'd14;
            if (cmd_err) err_seen = 1'b1;
            if (irom_rd) begin
                if (first < 0) first = edges;
                if (int'(irom_a) != rd_cnt) seq_ok = 1'b0;
                rd_cnt++;
            end
            if (first >= 0 && !busy) break;
        end
        cmd_valid = 1'b0;
        chk({tag, "_rd_cycles"}, rd_cnt, 64);
        chk({tag, "_busy_fall"}, edges - first, 65);
        chk({tag, "_addr_seq"}, seq_ok, 1);
        chk({tag, "_no_err"}, err_seen, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid_off"}, iram_valid, 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        bit err_seen;
        clk = 1'b0; reset = 1'b0;
        cmd = '0; cmd_valid = 1'b0; cmd2 = '0; cmd_valid2 = 1'b0;
        wr2_cnt = 0;
        for (int i = 0; i < 64; i++) rom[i] = i & 8'hFF;

        // Reset state and initial load
        @(negedge clk);
        @(negedge clk);
        chk("rst_irom_rd", irom_rd, 0);
        chk("rst_irom_a", irom_a, 0);
        chk("rst_iram_valid", iram_valid, 0);
        chk("rst_iram_d", iram_d, 0);
        chk("rst_iram_a", iram_a, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        reset = 1'b1;
        mimg = rom; rx = 4; ry = 4;
        measure_load("load");
        chk("load2_busy", busy2, 0);

        // Plain dump of the loaded image
        send(4'd0); idle(); wait_done("wr_plain");

        // Clamp to (1,1), then MAX over {0,1,8,9}
        repeat (5) send(4'd3);
        repeat (5) send(4'd1);
        send(4'd5); send(4'd0); idle(); wait_done("wr_max");
        chk("max_p0", ram[0], 9); chk("max_p1", ram[1], 9);
        chk("max_p2", ram[8], 9); chk("max_p3", ram[9], 9);

        // AVG without overflow on a fresh image
        rom[0] = 255; rom[1] = 255; rom[8] = 255; rom[9] = 254;
        send(4'd12); measure_load("reload1");
        send(4'd7); send(4'd0); idle(); wait_done("wr_avg");
        chk("avg_p0", ram[0], 254); chk("avg_p3", ram[9], 254);

        // Rotations and mirrors
        rom[0] = 1; rom[1] = 2; rom[8] = 3; rom[9] = 4;
        send(4'd12); measure_load("reload2");
        send(4'd9); send(4'd0); idle(); wait_done("wr_cw");
        chk("cw_p0", ram[0], 3); chk("cw_p1", ram[1], 1);
        chk("cw_p2", ram[8], 4); chk("cw_p3", ram[9], 2);
        send(4'd11); send(4'd11); send(4'd0); idle(); wait_done("wr_miry2");
        chk("miry2_p0", ram[0], 3); chk("miry2_p1", ram[1], 1);
        send(4'd8); send(4'd10); send(4'd6); send(4'd2); send(4'd4); send(4'd7);
        send(4'd11); send(4'd5); send(4'd0); idle(); wait_done("wr_mix");

        // Reserved code raises a one-cycle error flag only
        send(4'd14); idle();
        chk("err_pulse", cmd_err, 1);
        @(negedge clk);
        chk("err_clear", cmd_err, 0);

        // Commands during WRITE are ignored
        send(4'd0);
        err_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmd = (i % 4 == 0) ? 4'd3 : (i % 4 == 1) ? 4'd5 : (i % 4 == 2) ? 4'd12 : 4'd15;
            cmd_valid = 1'b1;
            if (cmd_err) err_seen = 1'b1;
        end
        cmd_valid = 1'b0;
        wait_done("wr_ignore");
        chk("ignore_no_err", err_seen, 0);

        // Reset in the middle of a WRITE aborts it and restarts the load
        send(4'd0); idle();
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_valid", iram_valid, 0);
        chk("midrst_busy", busy, 1);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        mimg = rom; rx = 4; ry = 4;
        measure_load("load_after_rst");
        send(4'd5); send(4'd0); idle(); wait_done("wr_after_rst");
        chk("oppt_reset", ram[36], 36);

        // 16x4 image: RIGHT x20 clamps X at 15, then MAX over {30,31,46,47}
        n = 0;
        while (busy2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("load2_ready", busy2, 0);
        @(negedge clk);
        cmd2 = 4'd4; cmd_valid2 = 1'b1;
        repeat (19) @(negedge clk);
        @(negedge clk); cmd2 = 4'd5;
        @(negedge clk); cmd2 = 4'd0;
        @(negedge clk); cmd_valid2 = 1'b0;
        n = 0;
        while (!done2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("w16_done", done2, 1);
        chk("w16_writes", wr2_cnt, 64);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("w16_ram%0d", i), ram2[i],
                (i == 30 || i == 31 || i == 46 || i == 47) ? 47 : i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
